mult_share_arbiter: RTL and testbench

//  Round-robin arbiter that shares one multiplier_sm instance among NUM_REQ requesters
//  (e.g. phi generation, modulus n = p*q, modexp squaring). It latches the winner's operands
//  and drives the multiplier start/done handshake. It returns the product with a one-cycle

---
 rtl/mult_share_arbiter.sv | 142 ++++++++++++++
 tb/tb_mult_share_arbiter.sv | 346 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mult_share_arbiter.sv
// Round-robin arbiter sharing one sequential multiplier among NUM_REQ requesters.
// Latches the winner's operands, runs the start/done handshake, and aborts stuck operations with a watchdog.
module mult_share_arbiter #(
    parameter int unsigned NUM_REQ = 3,
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned TIMEOUT = 1024
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic [NUM_REQ-1:0]         req,
    input  logic [NUM_REQ*WIDTH-1:0]   op_a,
    input  logic [NUM_REQ*WIDTH-1:0]   op_b,
    output logic [NUM_REQ-1:0]         done,
    output logic [WIDTH-1:0]           result,
    output logic                       err,
    output logic                       busy,
    output logic                       mult_start,
    output logic [WIDTH-1:0]           mult_in1,
    output logic [WIDTH-1:0]           mult_in2,
    input  logic                       mult_done,
    input  logic [WIDTH-1:0]           mult_out
);

    localparam int unsigned IW      = $clog2(NUM_REQ);
    localparam int unsigned TW      = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [TW-1:0] TLAST = TW'(TIMEOUT - 1);
    localparam logic [IW-1:0] PTR_RST = IW'(NUM_REQ - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_BUSY,
        ST_RESPOND,
        ST_RELEASE
    } state_t;

    state_t               r_state;
    logic [IW-1:0]        r_rr_ptr;
    logic [IW-1:0]        r_gnt;
    logic [TW-1:0]        r_timer;
    logic [NUM_REQ-1:0]   r_done;
    logic [WIDTH-1:0]     r_result;
    logic                 r_err;
    logic                 r_busy;
    logic                 r_start;
    logic [WIDTH-1:0]     r_in1;
    logic [WIDTH-1:0]     r_in2;

    logic [WIDTH-1:0]     w_a [NUM_REQ];
    logic [WIDTH-1:0]     w_b [NUM_REQ];
    logic                 w_found;
    logic [IW-1:0]        w_winner;
    logic [IW-1:0]        w_cand;

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
        assign w_a[g] = op_a[g*WIDTH +: WIDTH];
        assign w_b[g] = op_b[g*WIDTH +: WIDTH];
    end

    // First pending requester after the last winner, wrapping around.
    always_comb begin
        w_found  = 1'b0;
        w_winner = '0;
        w_cand   = '0;
        for (int k = 1; k <= int'(NUM_REQ); k++) begin
            w_cand = IW'((int'(r_rr_ptr) + k) % int'(NUM_REQ));
            if (!w_found && req[w_cand]) begin
                w_found  = 1'b1;
                w_winner = w_cand;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state  <= ST_IDLE;
            r_rr_ptr <= PTR_RST;
            r_gnt    <= '0;
            r_timer  <= '0;
            r_done   <= '0;
            r_result <= '0;
            r_err    <= 1'b0;
            r_busy   <= 1'b0;
            r_start  <= 1'b0;
            r_in1    <= '0;
            r_in2    <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_found) begin
                        r_gnt    <= w_winner;
                        r_rr_ptr <= w_winner;
                        r_in1    <= w_a[w_winner];
                        r_in2    <= w_b[w_winner];
                        r_start  <= 1'b1;
                        r_timer  <= '0;
                        r_busy   <= 1'b1;
                        r_state  <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    r_timer <= r_timer + TW'(1);
                    // A completing multiply beats a watchdog expiry in the same cycle.
                    if (mult_done) begin
                        r_result <= mult_out;
                        r_done   <= NUM_REQ'(1) << r_gnt;
                        r_err    <= 1'b0;
                        r_start  <= 1'b0;
                        r_state  <= ST_RESPOND;
                    end else if (TIMEOUT != 0 && r_timer == TLAST) begin
                        r_result <= '0;
                        r_done   <= NUM_REQ'(1) << r_gnt;
                        r_err    <= 1'b1;
                        r_start  <= 1'b0;
                        r_state  <= ST_RESPOND;
                    end
                end
                ST_RESPOND: begin
                    r_done  <= '0;
                    r_err   <= 1'b0;
                    r_state <= ST_RELEASE;
                end
                ST_RELEASE: begin
                    // Let the multiplier drop done before it can be started again.
                    if (!mult_done) begin
                        r_busy  <= 1'b0;
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign done       = r_done;
    assign result     = r_result;
    assign err        = r_err;
    assign busy       = r_busy;
    assign mult_start = r_start;
    assign mult_in1   = r_in1;
    assign mult_in2   = r_in2;

endmodule

// File: tb/tb_mult_share_arbiter.sv
// Directed bench for mult_share_arbiter: a latency-configurable multiplier model drives the main
// instance; a second instance with a short watchdog has its multiplier handshake driven by hand.
module tb_mult_share_arbiter;

    localparam int unsigned N = 3;
    localparam int unsigned W = 32;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             reset_n;
    logic [N-1:0]     req;
    logic [N*W-1:0]   op_a, op_b;
    logic [N-1:0]     done;
    logic [W-1:0]     result;
    logic             err, busy, mult_start, mult_done;
    logic [W-1:0]     mult_in1, mult_in2, mult_out;

    logic [N-1:0]     to_req;
    logic [N*W-1:0]   to_op_a, to_op_b;
    logic [N-1:0]     to_done;
    logic [W-1:0]     to_result;
    logic             to_err, to_busy, to_mstart, to_mdone;
    logic [W-1:0]     to_in1, to_in2, to_mout;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int lat = 3;
    int hold_extra = 0;
    int m_cnt, m_hold;

    mult_share_arbiter #(.NUM_REQ(N), .WIDTH(W), .TIMEOUT(1024)) dut (
        .clk(clk), .reset_n(reset_n), .req(req), .op_a(op_a), .op_b(op_b),
        .done(done), .result(result), .err(err), .busy(busy),
        .mult_start(mult_start), .mult_in1(mult_in1), .mult_in2(mult_in2),
        .mult_done(mult_done), .mult_out(mult_out)
    );

    mult_share_arbiter #(.NUM_REQ(N), .WIDTH(W), .TIMEOUT(16)) dut_to (
        .clk(clk), .reset_n(reset_n), .req(to_req), .op_a(to_op_a), .op_b(to_op_b),
        .done(to_done), .result(to_result), .err(to_err), .busy(to_busy),
        .mult_start(to_mstart), .mult_in1(to_in1), .mult_in2(to_in2),
        .mult_done(to_mdone), .mult_out(to_mout)
    );

    always @(posedge clk) cyc <= cyc + 1;

    // Multiplier model: done rises lat cycles after start, held while start is high plus hold_extra cycles.
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_cnt     <= 0;
            m_hold    <= 0;
            mult_done <= 1'b0;
            mult_out  <= '0;
        end else if (mult_start && !mult_done) begin
            if (m_cnt >= lat - 1) begin
                mult_done <= 1'b1;
                mult_out  <= mult_in1 * mult_in2;
            end else begin
                m_cnt <= m_cnt + 1;
            end
        end else if (!mult_start) begin
            m_cnt <= 0;
            if (mult_done) begin
                if (m_hold < hold_extra) m_hold <= m_hold + 1;
                else begin
                    mult_done <= 1'b0;
                    m_hold    <= 0;
                end
            end
        end
    end

    task automatic do_reset(input logic [N-1:0] r);
        reset_n    = 1'b0;
        req        = r;
        to_req     = '0;
        to_mdone   = 1'b0;
        to_mout    = '0;
        lat        = 3;
        hold_extra = 0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic wait_done(input int budget, output int at_cyc, output logic ok);
        ok     = 1'b0;
        at_cyc = 0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (done != '0) begin
                ok     = 1'b1;
                at_cyc = cyc;
                break;
            end
        end
    endtask

    task automatic test_reset();
        do_reset('0);
        checks++; if (done !== 3'b000) begin errors++; $display("FAIL reset_done: got %b want 000", done); end
        checks++; if (result !== 32'd0) begin errors++; $display("FAIL reset_result: got %0d want 0", result); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b want 0", err); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        checks++; if (mult_start !== 1'b0) begin errors++; $display("FAIL reset_start: got %b want 0", mult_start); end
        checks++; if (mult_in1 !== 32'd0 || mult_in2 !== 32'd0) begin
            errors++; $display("FAIL reset_operands: got %0d,%0d want 0,0", mult_in1, mult_in2);
        end
        checks++; if (to_busy !== 1'b0 || to_mstart !== 1'b0) begin
            errors++; $display("FAIL reset_to_inst: got busy=%b start=%b want 0,0", to_busy, to_mstart);
        end
    endtask

    task automatic test_single();
        int md_cyc, d_cyc;
        do_reset('0);
        lat = 34;
        op_a = '0; op_b = '0;
        op_a[31:0] = 32'd61;
        op_b[31:0] = 32'd53;
        op_a[63:32] = 32'd99;
        req = 3'b001;
        @(negedge clk);
        checks++; if (mult_start !== 1'b1 || busy !== 1'b1) begin
            errors++; $display("FAIL single_start: got start=%b busy=%b want 1,1", mult_start, busy);
        end
        checks++; if (mult_in1 !== 32'd61 || mult_in2 !== 32'd53) begin
            errors++; $display("FAIL single_operands: got %0d,%0d want 61,53", mult_in1, mult_in2);
        end
        md_cyc = -1; d_cyc = -1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (mult_done && md_cyc < 0) md_cyc = cyc;
            if (done != '0) begin d_cyc = cyc; break; end
        end
        checks++; if (d_cyc < 0 || done !== 3'b001) begin
            errors++; $display("FAIL single_done: got %b want 001", done);
        end
        checks++; if (result !== 32'd3233 || err !== 1'b0) begin
            errors++; $display("FAIL single_result: got %0d err=%b want 3233 err=0", result, err);
        end
        checks++; if (d_cyc - md_cyc != 1) begin
            errors++; $display("FAIL single_done_latency: got %0d want 1", d_cyc - md_cyc);
        end
        req = '0;
        @(negedge clk);
        checks++; if (done !== 3'b000 || result !== 32'd3233) begin
            errors++; $display("FAIL single_pulse_width: got done=%b result=%0d want 000,3233", done, result);
        end
        repeat (2) @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_idle: got busy=%b want 0", busy); end
    endtask

    task automatic test_contention();
        logic [N-1:0] exp_g [3] = '{3'b001, 3'b010, 3'b100};
        logic [W-1:0] exp_r [3] = '{32'd15, 32'd77, 32'hFFFF_FFFE};
        int c, last_c;
        logic ok;
        op_a = {32'hFFFF_FFFF, 32'd7, 32'd3};
        op_b = {32'd2, 32'd11, 32'd5};
        do_reset(3'b111);
        last_c = -10;
        for (int k = 0; k < 3; k++) begin
            wait_done(60, c, ok);
            checks++; if (!ok || done !== exp_g[k]) begin
                errors++; $display("FAIL contention_grant%0d: got %b want %b", k, done, exp_g[k]);
            end
            checks++; if (result !== exp_r[k]) begin
                errors++; $display("FAIL contention_result%0d: got %h want %h", k, result, exp_r[k]);
            end
            checks++; if (c - last_c < 4) begin
                errors++; $display("FAIL contention_spacing%0d: got %0d want >=4", k, c - last_c);
            end
            last_c = c;
            req = req & ~done;
            @(negedge clk);
            checks++; if (done !== 3'b000) begin
                errors++; $display("FAIL contention_pulse%0d: got %b want 000", k, done);
            end
        end
    endtask

    task automatic test_fairness();
        int c;
        logic ok;
        op_a = {32'd0, 32'd100, 32'd9};
        op_b = {32'd0, 32'd200, 32'd9};
        do_reset(3'b011);
        wait_done(40, c, ok);
        checks++; if (!ok || done !== 3'b001 || result !== 32'd81) begin
            errors++; $display("FAIL fair_first: got %b/%0d want 001/81", done, result);
        end
        req[0] = 1'b0;
        @(negedge clk);
        req[0] = 1'b1;
        wait_done(40, c, ok);
        checks++; if (!ok || done !== 3'b010 || result !== 32'd20000) begin
            errors++; $display("FAIL fair_second: got %b/%0d want 010/20000", done, result);
        end
        req[1] = 1'b0;
        wait_done(40, c, ok);
        checks++; if (!ok || done !== 3'b001) begin
            errors++; $display("FAIL fair_third: got %b want 001", done);
        end
        req = '0;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_timeout();
        int c1, c2;
        do_reset('0);
        to_op_a = '0; to_op_b = '0;
        to_op_a[31:0] = 32'd7;
        to_op_b[31:0] = 32'd6;
        // Multiplier done arrives on the very cycle the watchdog would fire.
        to_req = 3'b001;
        @(negedge clk);
        repeat (15) @(negedge clk);
        to_mdone = 1'b1;
        to_mout  = 32'd42;
        @(negedge clk);
        checks++; if (to_done !== 3'b001 || to_err !== 1'b0 || to_result !== 32'd42) begin
            errors++; $display("FAIL to_tie: got done=%b err=%b res=%0d want 001,0,42", to_done, to_err, to_result);
        end
        to_req = '0;
        to_mdone = 1'b0;
        repeat (3) @(negedge clk);
        to_req = 3'b001;
        @(negedge clk);
        c1 = cyc;
        checks++; if (to_mstart !== 1'b1) begin errors++; $display("FAIL to_start: got %b want 1", to_mstart); end
        c2 = -1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (to_done != '0) begin c2 = cyc; break; end
        end
        checks++; if (c2 - c1 != 16) begin
            errors++; $display("FAIL to_latency: got %0d want 16", c2 - c1);
        end
        checks++; if (to_done !== 3'b001 || to_err !== 1'b1 || to_result !== 32'd0 || to_mstart !== 1'b0) begin
            errors++; $display("FAIL to_abort: got done=%b err=%b res=%0d start=%b want 001,1,0,0",
                               to_done, to_err, to_result, to_mstart);
        end
        to_req = '0;
        @(negedge clk);
        checks++; if (to_done !== 3'b000 || to_err !== 1'b0) begin
            errors++; $display("FAIL to_pulse: got done=%b err=%b want 000,0", to_done, to_err);
        end
        repeat (2) @(negedge clk);
        checks++; if (to_busy !== 1'b0) begin errors++; $display("FAIL to_idle: got busy=%b want 0", to_busy); end
    endtask

    task automatic test_reset_mid();
        int c;
        logic ok;
        do_reset('0);
        lat = 2;
        op_a = {32'd0, 32'd4, 32'd5};
        op_b = {32'd0, 32'd4, 32'd9};
        req = 3'b001;
        wait_done(30, c, ok);
        checks++; if (!ok || result !== 32'd45) begin errors++; $display("FAIL mid_pre: got %0d want 45", result); end
        req = '0;
        repeat (3) @(negedge clk);
        lat = 100;
        req = 3'b001;
        repeat (5) @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        checks++; if (mult_start !== 1'b0 || busy !== 1'b0 || result !== 32'd0 || mult_in1 !== 32'd0 || done !== 3'b000) begin
            errors++; $display("FAIL mid_async: got start=%b busy=%b res=%0d in1=%0d done=%b want all 0",
                               mult_start, busy, result, mult_in1, done);
        end
        @(negedge clk);
        lat = 3;
        req = 3'b011;
        reset_n = 1'b1;
        wait_done(30, c, ok);
        checks++; if (!ok || done !== 3'b001) begin errors++; $display("FAIL mid_ptr: got %b want 001", done); end
        req[0] = 1'b0;
        wait_done(30, c, ok);
        checks++; if (!ok || done !== 3'b010 || result !== 32'd16) begin
            errors++; $display("FAIL mid_next: got %b/%0d want 010/16", done, result);
        end
        req = '0;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_slow_release();
        int c, t_low, t_start;
        logic ok;
        do_reset('0);
        lat = 2;
        hold_extra = 5;
        op_a = {32'd0, 32'd8, 32'd6};
        op_b = {32'd0, 32'd8, 32'd7};
        req = 3'b001;
        wait_done(30, c, ok);
        checks++; if (!ok || done !== 3'b001 || result !== 32'd42) begin
            errors++; $display("FAIL slow_first: got %b/%0d want 001/42", done, result);
        end
        checks++; if (mult_start !== 1'b0 || mult_done !== 1'b1) begin
            errors++; $display("FAIL slow_handshake: got start=%b mdone=%b want 0,1", mult_start, mult_done);
        end
        req = 3'b010;
        t_low = -1; t_start = -1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (!mult_done && t_low < 0) t_low = cyc;
            if (mult_start) begin t_start = cyc; break; end
        end
        checks++; if (t_low < 0 || t_start - t_low != 2) begin
            errors++; $display("FAIL slow_regrant: got low=%0d start=%0d want start=low+2", t_low, t_start);
        end
        wait_done(30, c, ok);
        checks++; if (!ok || done !== 3'b010 || result !== 32'd64) begin
            errors++; $display("FAIL slow_second: got %b/%0d want 010/64", done, result);
        end
        req = '0;
        repeat (10) @(negedge clk);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: got no finish want finish");
        $fatal(1);
    end

    initial begin
        reset_n = 1'b0;
        req = '0; op_a = '0; op_b = '0;
        to_req = '0; to_op_a = '0; to_op_b = '0; to_mdone = 1'b0; to_mout = '0;
        test_reset();
        test_single();
        test_contention();
        test_fairness();
        test_timeout();
        test_reset_mid();
        test_slow_release();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
